// File: rtl/pipeline_pkg.sv
// Shared types and constants for the MIDE pipeline control slice.
package pipeline_pkg;

  localparam int REG_W_DEF = 5;
  // Top bit of a register index selects the vector register file.
  localparam int VEC_BIT   = REG_W_DEF - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } ctrl_state_t;

  // Counter width for a count of n cycles, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Push-button synchronizer followed by a registered one-cycle rising-edge pulse.
module btn_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_pulse;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync[0] <= i_btn;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev  <= r_sync[STAGES-1];
      // Only a 0->1 transition fires; a held button stays quiet.
      r_pulse <= r_sync[STAGES-1] & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: start gating, load-use stall, branch flush, HALT drain.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int DRAIN_CYC   = 3,
  parameter int SYNC_STAGES = 2
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_button,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_halt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_load,
  input  logic             ex_branch_tkn,
  output logic             run,
  output logic             hold_if_id,
  output logic             clr_id_ex,
  output logic             flush_if_id,
  output logic             halted,
  output ctrl_state_t      dbg_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_stalls,
  output logic [CNT_W-1:0] perf_flushes
`endif
);

  localparam int            DW         = cnt_width(DRAIN_CYC);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  ctrl_state_t   r_state;
  ctrl_state_t   w_next;
  logic [DW-1:0] r_drain_cnt;
  logic          r_stall_q;

  logic w_start;
  logic w_in_run;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_stall;
  logic w_flush;
  logic w_halt_go;
  logic w_drain_done;

  btn_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_start_sync (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (start_button),
    .o_pulse (w_start)
  );

  // Full-width compare keeps scalar rN and vector rN apart.
  assign w_in_run   = (r_state == RUN);
  assign w_rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
  assign w_rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
  assign w_load_use = w_in_run & ex_load & (w_rs1_hit | w_rs2_hit);

  // A branch kills the ID instruction, so it wins over the stall. After one
  // stall cycle the load has moved on and forwarding covers the rest.
  assign w_stall      = w_load_use & ~ex_branch_tkn & ~r_stall_q;
  assign w_flush      = w_in_run & ex_branch_tkn;
  assign w_halt_go    = w_in_run & id_halt & ~ex_branch_tkn & ~w_stall;
  assign w_drain_done = (r_state == DRAIN) && (r_drain_cnt == DRAIN_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start)      w_next = RUN;
      RUN:     if (w_halt_go)    w_next = DRAIN;
      DRAIN:   if (w_drain_done) w_next = HALTED;
      HALTED:  if (w_start)      w_next = IDLE;
      default:                   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_drain_cnt <= '0;
      r_stall_q   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_stall_q <= w_stall;
      if ((r_state == DRAIN) && !w_drain_done) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

  always_comb begin
    run         = 1'b0;
    hold_if_id  = 1'b1;
    clr_id_ex   = 1'b1;
    flush_if_id = 1'b1;
    halted      = 1'b0;
    case (r_state)
      RUN: begin
        run         = 1'b1;
        hold_if_id  = w_stall;
        clr_id_ex   = w_stall | w_flush;
        flush_if_id = w_flush;
      end
      DRAIN: begin
        run         = 1'b1;
        flush_if_id = 1'b0;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        run = 1'b0;
      end
    endcase
  end

  assign dbg_state = r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_perf_cycles;
  logic [CNT_W-1:0] r_perf_stalls;
  logic [CNT_W-1:0] r_perf_flushes;

  // Counters restart with each run and stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst || ((r_state == IDLE) && w_start)) begin
      r_perf_cycles  <= '0;
      r_perf_stalls  <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_in_run && !(&r_perf_cycles)) begin
        r_perf_cycles <= r_perf_cycles + 1'b1;
      end
      if (w_stall && !(&r_perf_stalls)) begin
        r_perf_stalls <= r_perf_stalls + 1'b1;
      end
      if (w_flush && !(&r_perf_flushes)) begin
        r_perf_flushes <= r_perf_flushes + 1'b1;
      end
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_stalls  = r_perf_stalls;
  assign perf_flushes = r_perf_flushes;
`endif

endmodule
